// File: rtl/store_pkg.sv
// Shared types for the store packer: size encodings, the AdES code and the
// write-buffer entry layout.
package store_pkg;

  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BE_W         = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } st_size_e;

  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]       wdata;
    logic [BE_W-1:0]         byteen;
  } store_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// Replicates right-aligned store data across byte lanes and derives the byte
// enables and the alignment fault for one store request.
module store_lane_pack
  import store_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   byteen,
  output logic              misaligned
);

  always_comb begin
    wdata      = data;
    byteen     = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata  = {4{data[7:0]}};
        byteen = 4'b0001 << offset;
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
        byteen     = offset[1] ? 4'b1100 : 4'b0011;
        misaligned = offset[0];
      end
      SZ_WORD: begin
        byteen     = 4'b1111;
        misaligned = (offset != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_packer.sv
// Store packer: aligns sb/sh/sw into word writes, buffers them in a small FIFO
// toward data memory and flags AdES. Define STORE_FWD_EN for store-to-load forwarding.
module store_packer
  import store_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              st_exc,
  output logic [ADDR_W-1:0] st_exc_addr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byteen
`ifdef STORE_FWD_EN
  ,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              fwd_hit,
  output logic [31:0]       fwd_data,
  output logic [3:0]        fwd_byteen
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  store_entry_t      fifo [DEPTH];
  store_entry_t      head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] pk_wdata;
  logic [BE_W-1:0]   pk_byteen;
  logic              pk_mis;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;

  store_lane_pack u_lane_pack (
    .size       (st_size),
    .offset     (st_addr[1:0]),
    .data       (st_data),
    .wdata      (pk_wdata),
    .byteen     (pk_byteen),
    .misaligned (pk_mis)
  );

  assign full     = (count == CNT_W'(DEPTH));
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !pk_mis && !flush;
  assign pop      = mem_valid && mem_ready;

  assign head       = fifo[rd_ptr];
  assign mem_valid  = (count != '0);
  assign mem_addr   = ADDR_W'(head.addr);
  assign mem_wdata  = head.wdata;
  assign mem_byteen = head.byteen;

  // Buffer storage and occupancy; flush wins over any push in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{addr:   ENTRY_ADDR_W'({st_addr[ADDR_W-1:2], 2'b00}),
                          wdata:  pk_wdata,
                          byteen: pk_byteen};
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Address-error report; the faulting address is held until the next fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_exc      <= 1'b0;
      st_exc_addr <= '0;
    end else begin
      st_exc <= accept && pk_mis;
      if (accept && pk_mis) st_exc_addr <= st_addr;
    end
  end

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0]  fwd_idx;
  logic [ADDR_W-1:0] fwd_ent_addr;

  // Walk oldest to youngest so younger matches overwrite older lanes.
  always_comb begin
    fwd_data     = '0;
    fwd_byteen   = '0;
    fwd_idx      = '0;
    fwd_ent_addr = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx      = rd_ptr + PTR_W'(i);
      fwd_ent_addr = ADDR_W'(fifo[fwd_idx].addr);
      if ((CNT_W'(i) < count) && (((fwd_ent_addr ^ ld_addr) >> 2) == '0)) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (fifo[fwd_idx].byteen[b]) fwd_data[8*b +: 8] = fifo[fwd_idx].wdata[8*b +: 8];
        end
        fwd_byteen = fwd_byteen | fifo[fwd_idx].byteen;
      end
    end
  end

  assign fwd_hit = |fwd_byteen;
`endif

endmodule

// File: tb/tb_store_packer.sv
// Self-checking bench for store_packer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_store_packer;
  import store_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_exc;
  logic [31:0] st_exc_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
`ifdef STORE_FWD_EN
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_byteen;
`endif

  always #5 clk = ~clk;

  store_packer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_exc      (st_exc),
    .st_exc_addr (st_exc_addr),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byteen  (mem_byteen)
`ifdef STORE_FWD_EN
    ,
    .ld_addr     (ld_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .fwd_byteen  (fwd_byteen)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ment_t;

  ment_t       q[$];
  logic        exp_exc;
  logic [31:0] exp_exc_addr;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference packing straight from the size/offset rules.
  function automatic void ref_pack(input logic [1:0] sz, input logic [31:0] a,
                                   input logic [31:0] d, output ment_t e, output bit bad);
    e.a  = a & ~32'h3;
    e.d  = d;
    e.be = 4'h0;
    bad  = 1'b0;
    case (sz)
      2'd0: begin e.d = {24'h0, d[7:0]} * 32'h0101_0101; e.be = 4'(1 << a[1:0]); end
      2'd1: begin e.d = {16'h0, d[15:0]} * 32'h0001_0001; e.be = a[1] ? 4'hC : 4'h3; bad = a[0]; end
      2'd2: begin e.be = 4'hF; bad = (a[1:0] != 2'b00); end
      default: bad = 1'b1;
    endcase
  endfunction

  task automatic model_update(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic mr, input logic fl);
    ment_t e;
    bit    bad;
    bit    acc;
    bit    pp;
    ref_pack(sz, a, d, e, bad);
    acc     = v && (q.size() < DEPTH);
    pp      = (q.size() != 0) && mr;
    exp_exc = acc && bad;
    if (acc && bad) exp_exc_addr = a;
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc && !bad) q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    check("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
    check("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
    check("st_exc", 32'(st_exc), 32'(exp_exc));
    check("st_exc_addr", st_exc_addr, exp_exc_addr);
    if (q.size() != 0) begin
      check("mem_addr", mem_addr, q[0].a);
      check("mem_wdata", mem_wdata, q[0].d);
      check("mem_byteen", 32'(mem_byteen), 32'(q[0].be));
    end
`ifdef STORE_FWD_EN
    begin
      logic [31:0] fd;
      logic [3:0]  fb;
      fd = '0;
      fb = '0;
      foreach (q[i]) begin
        if (q[i].a[31:2] == ld_addr[31:2]) begin
          for (int b = 0; b < 4; b++) if (q[i].be[b]) fd[8*b +: 8] = q[i].d[8*b +: 8];
          fb = fb | q[i].be;
        end
      end
      check("fwd_byteen", 32'(fwd_byteen), 32'(fb));
      check("fwd_data", fwd_data, fd);
      check("fwd_hit", 32'(fwd_hit), 32'(fb != 4'h0));
    end
`endif
  endtask

  // Called at a falling edge: drive, take one rising edge, then verify.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic mr, input logic fl);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_size   = sz;
    mem_ready = mr;
    flush     = fl;
    @(posedge clk);
    model_update(v, a, d, sz, mr, fl);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_size   = '0;
    mem_ready = 1'b0;
`ifdef STORE_FWD_EN
    ld_addr   = '0;
`endif
    exp_exc      = 1'b0;
    exp_exc_addr = '0;

    #12;
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_st_ready", 32'(st_ready), 32'h1);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_byteen", 32'(mem_byteen), 32'h0);
    check("rst_st_exc", 32'(st_exc), 32'h0);
    check("rst_st_exc_addr", st_exc_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a burst.
    step(1'b1, 32'h0000_0100, 32'h1111_1111, SZ_WORD, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0104, 32'h2222_2222, SZ_WORD, 1'b0, 1'b0);
    check("burst_full", 32'(st_ready), 32'h0);
    st_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_valid", 32'(mem_valid), 32'h0);
    check("midrst_st_ready", 32'(st_ready), 32'h1);
    q.delete();
    exp_exc      = 1'b0;
    exp_exc_addr = '0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
    check("no_stale", 32'(mem_valid), 32'h0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);

    // Byte store into the top lane.
    step(1'b1, 32'h0000_1003, 32'h1234_56AB, SZ_BYTE, 1'b1, 1'b0);
    check("sb_addr", mem_addr, 32'h0000_1000);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_byteen", 32'(mem_byteen), 32'h8);
    drain();

    // Halfword then misaligned word.
    step(1'b1, 32'h0000_2002, 32'hFFFF_BEEF, SZ_HALF, 1'b0, 1'b0);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_byteen", 32'(mem_byteen), 32'hC);
    step(1'b1, 32'h0000_2001, 32'hCAFE_F00D, SZ_WORD, 1'b0, 1'b0);
    check("ades_exc", 32'(st_exc), 32'h1);
    check("ades_addr", st_exc_addr, 32'h0000_2001);
    check("ades_no_write", mem_addr, 32'h0000_2000);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    check("ades_pulse", 32'(st_exc), 32'h0);
    check("ades_hold", st_exc_addr, 32'h0000_2001);
    drain();

    // Backpressure with a third store held at the input.
    step(1'b1, 32'h0000_4000, 32'hA0A0_A0A0, SZ_WORD, 1'b0, 1'b0);
    step(1'b1, 32'h0000_4004, 32'hB1B1_B1B1, SZ_WORD, 1'b0, 1'b0);
    check("bp_ready", 32'(st_ready), 32'h0);
    step(1'b1, 32'h0000_4008, 32'hC2C2_C2C2, SZ_WORD, 1'b0, 1'b0);
    check("bp_stable", mem_addr, 32'h0000_4000);
    step(1'b1, 32'h0000_4008, 32'hC2C2_C2C2, SZ_WORD, 1'b1, 1'b0);
    check("bp_second", mem_addr, 32'h0000_4004);
    step(1'b1, 32'h0000_4008, 32'hC2C2_C2C2, SZ_WORD, 1'b1, 1'b0);
    check("bp_third", mem_addr, 32'h0000_4008);
    drain();

    // Flush with two entries while the head is being accepted.
    step(1'b1, 32'h0000_5000, 32'h0000_0001, SZ_WORD, 1'b0, 1'b0);
    step(1'b1, 32'h0000_5004, 32'h0000_0002, SZ_WORD, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1);
    check("flush_empty", 32'(mem_valid), 32'h0);
    drain();

`ifdef STORE_FWD_EN
    ld_addr = 32'h0000_3000;
    step(1'b1, 32'h0000_3000, 32'h0000_0010, SZ_BYTE, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3000, 32'h0000_0020, SZ_BYTE, 1'b0, 1'b0);
    check("fwd_dir_hit", 32'(fwd_hit), 32'h1);
    check("fwd_dir_be", 32'(fwd_byteen), 32'h1);
    check("fwd_dir_data", 32'(fwd_data[7:0]), 32'h20);
    drain();
`endif

    // Random traffic over a narrow address window.
    for (int i = 0; i < 400; i++) begin
`ifdef STORE_FWD_EN
      ld_addr = 32'h0000_3000 + 32'($urandom_range(0, 15));
`endif
      step(1'($urandom_range(0, 9) < 7),
           32'h0000_3000 + 32'($urandom_range(0, 15)),
           $urandom,
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
